// File: rtl/csa_acc_seq.sv
// Sequential signed accumulator: terms are compressed 3:2 into a carry-save pair (S, C),
// resolved once per sum, then held until accepted. Define CSA_ACC_SAT_EN to clamp out_data.
module csa_acc_seq #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_terms
);

`ifdef CSA_ACC_SAT_EN
    localparam int R_W = ACC_W;
`else
    // Only the low OUT_W bits of the resolved sum are ever observed when truncating.
    localparam int R_W = OUT_W;
`endif

    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   s_reg, s_next;
    logic [ACC_W-1:0]   c_reg, c_next;
    logic [R_W-1:0]     r_reg, r_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   csa_sum;
    logic [ACC_W-1:0]   csa_carry;
    logic               in_fire;

    assign x_ext = ACC_W'($signed(in_data));

    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_sum
            assign csa_sum[gi] = s_reg[gi] ^ c_reg[gi] ^ x_ext[gi];
        end
        // Majority of bit gi-1 lands in bit gi; the top majority bit is shifted out.
        assign csa_carry[0] = 1'b0;
        for (gi = 1; gi < ACC_W; gi++) begin : g_carry
            assign csa_carry[gi] = (s_reg[gi-1] & c_reg[gi-1]) |
                                   (s_reg[gi-1] & x_ext[gi-1]) |
                                   (c_reg[gi-1] & x_ext[gi-1]);
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE) || (state_reg == ACC);
    assign out_valid = (state_reg == OUT);
    assign out_terms = cnt_reg;
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        c_next     = c_reg;
        r_next     = r_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    s_next     = x_ext;
                    c_next     = '0;
                    cnt_next   = CNT_W'(1);
                    state_next = in_last ? RESOLVE : ACC;
                end
            end
            ACC: begin
                if (in_fire) begin
                    s_next     = csa_sum;
                    c_next     = csa_carry;
                    cnt_next   = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
                    state_next = in_last ? RESOLVE : ACC;
                end
            end
            RESOLVE: begin
                r_next     = R_W'(s_reg + c_reg);
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            c_reg     <= c_next;
            r_reg     <= r_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef CSA_ACC_SAT_EN
    localparam int HI_W = ACC_W - OUT_W + 1;
    // In range when every bit from the OUT_W sign position upward agrees.
    always_comb begin
        if ((r_reg[ACC_W-1:OUT_W-1] == {HI_W{1'b0}}) ||
            (r_reg[ACC_W-1:OUT_W-1] == {HI_W{1'b1}})) begin
            out_data = r_reg[OUT_W-1:0];
        end else if (r_reg[ACC_W-1]) begin
            out_data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            out_data = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign out_data = r_reg;
`endif

endmodule

// File: tb/tb_csa_acc_seq.sv
// Directed bench for csa_acc_seq: table of short sums plus hand-written
// back-pressure, bubble, saturation and reset sequences.
module tb_csa_acc_seq;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 24;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_terms;

    int n_assert = 0;
    int n_fail   = 0;

    csa_acc_seq #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_terms(out_terms)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int t0, t1, t2, t3;
        int exp_data;
        int exp_terms;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    // Present one operand and hold it until it is taken (bounded).
    task automatic send(input int v, input bit last);
        int budget;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        in_last  = last;
        budget   = 20;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready) chk("send_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the in_last transfer: checks T+1 and T+2, then result.
    task automatic expect_result(input string name, input longint d, input longint t);
        chk({name, "_t1_out_valid"}, out_valid, 0);
        chk({name, "_t1_in_ready"}, in_ready, 0);
        tick();
        chk({name, "_t2_out_valid"}, out_valid, 1);
        chk({name, "_t2_in_ready"}, in_ready, 0);
        chk({name, "_data"}, sdata(), d);
        chk({name, "_terms"}, out_terms, t);
        $display("%s: out_data=%0d out_terms=%0d", name, sdata(), out_terms);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_idle_out_valid"}, out_valid, 0);
        chk({name, "_idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        longint wrap_exp;
        int tv [4];

        vecs[0] = '{n: 1, t0: -5,    t1: 0,     t2: 0,      t3: 0,      exp_data: -5,  exp_terms: 1};
        vecs[1] = '{n: 4, t0: 100,   t1: -3,    t2: 7,      t3: 20,     exp_data: 124, exp_terms: 4};
        vecs[2] = '{n: 4, t0: 32767, t1: 32767, t2: -32768, t3: -32768, exp_data: -2,  exp_terms: 4};
        vecs[3] = '{n: 3, t0: -1,    t1: -1,    t2: -1,     t3: 0,      exp_data: -3,  exp_terms: 3};
        vecs[4] = '{n: 2, t0: 0,     t1: 0,     t2: 0,      t3: 0,      exp_data: 0,   exp_terms: 2};
        vecs[5] = '{n: 3, t0: 12345, t1: -12345, t2: 1,     t3: 0,      exp_data: 1,   exp_terms: 3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", sdata(), 0);
        chk("reset_out_terms", out_terms, 0);
        chk("reset_in_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table-driven back-to-back sums
        foreach (vecs[i]) begin
            tv = '{vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3};
            for (int k = 0; k < vecs[i].n; k++) send(tv[k], k == vecs[i].n - 1);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_terms);
        end

        // Back-pressure: result held 5 cycles; offered operand must not be taken
        send(10, 1'b0);
        send(20, 1'b1);
        chk("bp_t1_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b1; in_data = DATA_W'(99); in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_data", sdata(), 30);
            chk("bp_terms", out_terms, 2);
            chk("bp_in_ready", in_ready, 0);
            $display("bp cycle %0d: out_valid=%0d out_data=%0d", k, out_valid, sdata());
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_no_capture", out_valid, 0);
        end

        // Input bubbles: in_valid 1,0,0,1,1
        in_valid = 1'b1; in_data = DATA_W'(1); tick();
        in_valid = 1'b0; tick();
        chk("bubble_hold_out_valid", out_valid, 0);
        chk("bubble_hold_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b1; in_data = DATA_W'(2); tick();
        in_data = DATA_W'(3); in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("bubble", 6, 3);

        // 300 x 32767 = 9830100: exceeds OUT_W range, count saturates
`ifdef CSA_ACC_SAT_EN
        wrap_exp = 8388607;
`else
        wrap_exp = 9830100 - 16777216;
`endif
        for (int k = 0; k < 300; k++) send(32767, k == 299);
        expect_result("overflow", wrap_exp, 255);

        // Reset mid-sum discards partial result
        send(5, 1'b0);
        send(6, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_terms", out_terms, 0);
        tick();
        rst = 1'b0;
        chk("rst_mid_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_mid_no_output", out_valid, 0);
        end
        send(1, 1'b0);
        send(1, 1'b1);
        expect_result("after_rst", 2, 2);

        // Reset while a result is pending
        send(7, 1'b1);
        tick();
        chk("rst_out_pending", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", sdata(), 0);
        chk("rst_out_terms", out_terms, 0);
        tick();
        rst = 1'b0;
        chk("rst_out_in_ready", in_ready, 1);
        tick();
        chk("rst_out_no_output", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
